// File: rtl/avalon_pkg.sv
// Shared types and helpers for the Avalon-ST width converters.
package avalon_pkg;

  localparam int DEFAULT_SYMBOL_WIDTH = 8;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_ACTIVE = 1'b1
  } hold_state_t;

  // Width of an empty field for a beat of the given symbol count (never zero).
  function automatic int empty_width(input int symbols);
    return (symbols > 1) ? $clog2(symbols) : 1;
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST stream bundle with packet framing and valid/ready handshake.
interface avalon_st_if #(
  parameter int DATA_WIDTH  = 64,
  parameter int EMPTY_WIDTH = 3
) ();

  logic [DATA_WIDTH-1:0]  data;
  logic [EMPTY_WIDTH-1:0] empty;
  logic                   sop;
  logic                   eop;
  logic                   vld;
  logic                   rdy;

  modport master (output data, empty, sop, eop, vld, input rdy);
  modport slave  (input data, empty, sop, eop, vld, output rdy);

endinterface

// File: rtl/avalon_downsizer_sub_beat_cnt.sv
// Sub-beat counter for the downsizer; flags the final sub-beat of the held input beat
// and reports the empty value that sub-beat must carry when it closes a packet.
module avalon_downsizer_sub_beat_cnt #(
  parameter int IN_SYMBOLS      = 8,
  parameter int RATIO           = 4,
  parameter int EMPTY_WIDTH     = 3,
  parameter int OUT_EMPTY_WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic                       advance,
  input  logic                       eop,
  input  logic [EMPTY_WIDTH-1:0]     empty,
  output logic [$clog2(RATIO)-1:0]   cnt,
  output logic                       last,
  output logic [OUT_EMPTY_WIDTH-1:0] last_empty
);

  localparam int CW          = $clog2(RATIO);
  localparam int OUT_SYMBOLS = IN_SYMBOLS / RATIO;
  localparam int OUT_SHIFT   = $clog2(OUT_SYMBOLS);

  logic [CW-1:0]          cnt_reg;
  logic [EMPTY_WIDTH-1:0] valid_m1;
  logic [EMPTY_WIDTH-1:0] rem;
  logic [CW-1:0]          last_idx;

  // Index of the last valid symbol; its sub-beat is the final one of an eop beat.
  assign valid_m1 = EMPTY_WIDTH'(IN_SYMBOLS - 1) - empty;
  assign rem      = valid_m1 & EMPTY_WIDTH'(OUT_SYMBOLS - 1);
  assign last_idx = eop ? CW'(valid_m1 >> OUT_SHIFT) : CW'(RATIO - 1);

  assign cnt        = cnt_reg;
  assign last       = (cnt_reg == last_idx);
  assign last_empty = OUT_EMPTY_WIDTH'(EMPTY_WIDTH'(OUT_SYMBOLS - 1) - rem);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load || (advance && last)) begin
      cnt_reg <= '0;
    end else if (advance) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/avalon_downsizer.sv
// Avalon-ST width downsizer: splits each wide input beat into RATIO narrow beats,
// trimming the final packet beat by its empty count and flagging framing errors.
module avalon_downsizer
  import avalon_pkg::*;
#(
  parameter int SYMBOL_WIDTH = DEFAULT_SYMBOL_WIDTH,
  parameter int IN_SYMBOLS   = 8,
  parameter int RATIO        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  avalon_st_if.slave  msg_in,
  avalon_st_if.master msg_out,
  output logic        frame_err
);

  localparam int OUT_SYMBOLS = IN_SYMBOLS / RATIO;
  localparam int IN_WIDTH    = SYMBOL_WIDTH * IN_SYMBOLS;
  localparam int OUT_WIDTH   = SYMBOL_WIDTH * OUT_SYMBOLS;
  localparam int IN_EW       = empty_width(IN_SYMBOLS);
  localparam int OUT_EW      = empty_width(OUT_SYMBOLS);
  localparam int CW          = $clog2(RATIO);

  if (IN_SYMBOLS < 2 || (IN_SYMBOLS & (IN_SYMBOLS - 1)) != 0) begin : g_bad_in_symbols
    $fatal(1, "avalon_downsizer: IN_SYMBOLS must be a power of 2, at least 2");
  end
  if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0 || (IN_SYMBOLS % RATIO) != 0) begin : g_bad_ratio
    $fatal(1, "avalon_downsizer: RATIO must be a power of 2, at least 2, dividing IN_SYMBOLS");
  end
  if ($bits(msg_in.data) != IN_WIDTH || $bits(msg_in.empty) != IN_EW) begin : g_bad_in_if
    $fatal(1, "avalon_downsizer: msg_in width mismatch");
  end
  if ($bits(msg_out.data) != OUT_WIDTH || $bits(msg_out.empty) != OUT_EW) begin : g_bad_out_if
    $fatal(1, "avalon_downsizer: msg_out width mismatch");
  end

  hold_state_t          state_reg, state_next;
  logic [IN_WIDTH-1:0]  data_reg;
  logic [IN_EW-1:0]     empty_reg;
  logic                 sop_reg;
  logic                 eop_reg;
  logic                 in_pkt_reg;
  logic                 frame_err_reg;

  logic                 in_rdy;
  logic                 out_vld;
  logic                 in_xfer;
  logic                 out_xfer;
  logic [CW-1:0]        cnt;
  logic                 last;
  logic [OUT_EW-1:0]    last_empty;
  logic [OUT_WIDTH-1:0] slice [RATIO];

  assign in_xfer  = msg_in.vld & in_rdy;
  assign out_xfer = out_vld & msg_out.rdy;

  // Ready only depends on registered state and downstream ready, never on msg_in.vld.
  always_comb begin
    state_next = state_reg;
    in_rdy     = 1'b0;
    out_vld    = 1'b0;
    case (state_reg)
      ST_EMPTY: begin
        in_rdy = 1'b1;
        if (msg_in.vld) state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        out_vld = 1'b1;
        in_rdy  = last & msg_out.rdy;
        if (last && msg_out.rdy && !msg_in.vld) state_next = ST_EMPTY;
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_EMPTY;
      data_reg  <= '0;
      empty_reg <= '0;
      sop_reg   <= 1'b0;
      eop_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (in_xfer) begin
        data_reg  <= msg_in.data;
        empty_reg <= msg_in.empty;
        sop_reg   <= msg_in.sop;
        eop_reg   <= msg_in.eop;
      end
    end
  end

  // A sop while inside a packet, or a non-sop outside one, is a framing violation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_pkt_reg    <= 1'b0;
      frame_err_reg <= 1'b0;
    end else if (in_xfer) begin
      frame_err_reg <= (msg_in.sop == in_pkt_reg);
      in_pkt_reg    <= (msg_in.sop | in_pkt_reg) & ~msg_in.eop;
    end else begin
      frame_err_reg <= 1'b0;
    end
  end

  avalon_downsizer_sub_beat_cnt #(
    .IN_SYMBOLS      (IN_SYMBOLS),
    .RATIO           (RATIO),
    .EMPTY_WIDTH     (IN_EW),
    .OUT_EMPTY_WIDTH (OUT_EW)
  ) u_sub_beat_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (in_xfer),
    .advance    (out_xfer),
    .eop        (eop_reg),
    .empty      (empty_reg),
    .cnt        (cnt),
    .last       (last),
    .last_empty (last_empty)
  );

  // Symbol 0 sits at the MSBs, so sub-beat 0 is the top slice.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
    assign slice[gi] = data_reg[IN_WIDTH-1-gi*OUT_WIDTH -: OUT_WIDTH];
  end

  assign msg_in.rdy    = in_rdy;
  assign msg_out.vld   = out_vld;
  assign msg_out.data  = slice[cnt];
  assign msg_out.sop   = sop_reg & (cnt == '0);
  assign msg_out.eop   = eop_reg & last;
  assign msg_out.empty = (eop_reg & last) ? last_empty : '0;
  assign frame_err     = frame_err_reg;

endmodule

// File: tb/tb_avalon_downsizer.sv
// Bench for avalon_downsizer: directed framing/timing steps plus randomized traffic,
// all checked against a symbol-level model of the packet split.
module tb_avalon_downsizer;

  typedef struct packed {
    logic [15:0] data;
    logic [0:0]  empty;
    logic        sop;
    logic        eop;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic frame_err;

  avalon_st_if #(.DATA_WIDTH(64), .EMPTY_WIDTH(3)) in_if ();
  avalon_st_if #(.DATA_WIDTH(16), .EMPTY_WIDTH(1)) out_if ();

  avalon_downsizer #(
    .SYMBOL_WIDTH (8),
    .IN_SYMBOLS   (8),
    .RATIO        (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .msg_in    (in_if),
    .msg_out   (out_if),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    passes = 0;
  beat_t exp_q[$];
  bit    model_in_pkt = 1'b0;
  bit    fe_pending   = 1'b0;
  bit    rand_rdy     = 1'b0;
  bit    stall_prev   = 1'b0;
  beat_t stall_beat;
  bit    last_vld, last_in_rdy, last_in_acc;
  int    fe_pulses  = 0;
  int    vld_cycles = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Split one accepted input beat into the narrow beats the packet rules call for.
  function automatic void model_accept(input logic [63:0] d, input logic [2:0] e,
                                       input logic sop, input logic eop);
    int         v, n;
    logic [7:0] sym [8];
    beat_t      b;
    v = eop ? 8 - int'(e) : 8;
    n = (v + 1) / 2;
    for (int i = 0; i < 8; i++) sym[i] = d[63-8*i -: 8];
    for (int k = 0; k < n; k++) begin
      b.data  = {sym[2*k], sym[2*k+1]};
      b.sop   = sop && (k == 0);
      b.eop   = eop && (k == n - 1);
      b.empty = b.eop ? 1'(2 * n - v) : 1'b0;
      exp_q.push_back(b);
    end
  endfunction

  task automatic tick();
    beat_t       obs, e;
    logic [15:0] mask;
    @(negedge clk);
    obs.data  = out_if.data;
    obs.empty = out_if.empty;
    obs.sop   = out_if.sop;
    obs.eop   = out_if.eop;
    chk("frame_err", frame_err, fe_pending);
    if (frame_err) fe_pulses++;
    if (stall_prev && out_if.vld) chk("stall_hold", obs, stall_beat);
    if (out_if.vld) vld_cycles++;
    if (out_if.vld && out_if.rdy) begin
      chk("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e    = exp_q.pop_front();
        mask = e.empty ? 16'hFF00 : 16'hFFFF;
        chk("beat_data", obs.data & mask, e.data & mask);
        chk("beat_ctrl", {obs.empty, obs.sop, obs.eop}, {e.empty, e.sop, e.eop});
      end
    end
    stall_prev  = out_if.vld && !out_if.rdy;
    stall_beat  = obs;
    last_vld    = out_if.vld;
    last_in_rdy = in_if.rdy;
    last_in_acc = in_if.vld && in_if.rdy && rst_n;
    fe_pending  = 1'b0;
    if (last_in_acc) begin
      fe_pending   = (in_if.sop == model_in_pkt);
      model_in_pkt = (in_if.sop | model_in_pkt) & ~in_if.eop;
      model_accept(in_if.data, in_if.empty, in_if.sop, in_if.eop);
    end
    @(posedge clk);
    #1;
    out_if.rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [2:0] e,
                           input logic sop, input logic eop);
    int guard = 0;
    in_if.data  = d;
    in_if.empty = e;
    in_if.sop   = sop;
    in_if.eop   = eop;
    in_if.vld   = 1'b1;
    do begin
      tick();
      guard++;
    end while (!last_in_acc && guard < 200);
    chk("send_accept", last_in_acc, 1);
    in_if.vld = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || out_if.vld) && guard < 500) begin
      tick();
      guard++;
    end
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_idle", out_if.vld, 0);
  endtask

  initial begin
    logic [63:0] pat;
    int          len;
    pat         = 64'h0011_2233_4455_6677;
    in_if.vld   = 1'b0;
    in_if.data  = '0;
    in_if.empty = '0;
    in_if.sop   = 1'b0;
    in_if.eop   = 1'b0;
    out_if.rdy  = 1'b1;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_vld", out_if.vld, 0);
    chk("rst_in_rdy", in_if.rdy, 1);
    chk("rst_data", {out_if.data, out_if.empty, out_if.sop, out_if.eop}, 0);
    chk("rst_frame_err", frame_err, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_vld", last_vld, 0);
    chk("post_rst_in_rdy", last_in_rdy, 1);

    // Single full sop+eop beat: four consecutive narrow beats
    send_beat(pat, 3'd0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("full_beat_vld", last_vld, 1);
    end
    tick();
    chk("full_beat_done", last_vld, 0);
    drain();

    // Trimmed eop beats
    vld_cycles = 0;
    send_beat(pat, 3'd3, 1'b1, 1'b1);
    drain();
    chk("empty3_beats", vld_cycles, 3);
    vld_cycles = 0;
    send_beat(pat, 3'd6, 1'b1, 1'b1);
    drain();
    chk("empty6_beats", vld_cycles, 1);

    // Back-to-back input beats: no output gap, input ready only on last sub-beat
    in_if.data  = 64'hA0A1_A2A3_A4A5_A6A7;
    in_if.empty = 3'd0;
    in_if.sop   = 1'b1;
    in_if.eop   = 1'b0;
    in_if.vld   = 1'b1;
    tick();
    chk("b2b_accept_first", last_in_acc, 1);
    in_if.data = 64'hB0B1_B2B3_B4B5_B6B7;
    in_if.sop  = 1'b0;
    in_if.eop  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("b2b_vld", last_vld, 1);
      chk("b2b_in_rdy", last_in_rdy, (i == 4) || (i == 8));
      if (i == 4) begin
        chk("b2b_accept_second", last_in_acc, 1);
        in_if.vld = 1'b0;
      end
    end
    tick();
    chk("b2b_done", last_vld, 0);
    drain();

    // Randomized traffic with random downstream stalls
    rand_rdy = 1'b1;
    for (int p = 0; p < 12; p++) begin
      len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++) begin
        repeat ($urandom_range(0, 2)) tick();
        send_beat({$urandom, $urandom}, 3'($urandom_range(0, 7)), b == 0, b == len - 1);
      end
    end
    drain();
    rand_rdy = 1'b0;

    // Framing violations: repeated sop, then non-sop outside a packet
    fe_pulses = 0;
    send_beat(64'h1111_1111_1111_1111, 3'd0, 1'b1, 1'b0);
    send_beat(64'h2222_2222_2222_2222, 3'd0, 1'b1, 1'b0);
    send_beat(64'h3333_3333_3333_3333, 3'd0, 1'b0, 1'b1);
    send_beat(64'h4444_4444_4444_4444, 3'd2, 1'b0, 1'b1);
    send_beat(64'h5555_5555_5555_5555, 3'd0, 1'b1, 1'b1);
    drain();
    chk("frame_err_pulses", fe_pulses, 2);

    // Reset while sub-beat 2 is on the output
    send_beat(64'hC0C1_C2C3_C4C5_C6C7, 3'd0, 1'b1, 1'b0);
    tick();
    tick();
    chk("pre_rst_vld", out_if.vld, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", out_if.vld, 0);
    chk("mid_rst_in_rdy", in_if.rdy, 1);
    chk("mid_rst_data", {out_if.data, out_if.empty, out_if.sop, out_if.eop}, 0);
    exp_q.delete();
    model_in_pkt = 1'b0;
    fe_pending   = 1'b0;
    stall_prev   = 1'b0;
    tick();
    tick();
    rst_n      = 1'b1;
    vld_cycles = 0;
    send_beat(64'hD0D1_D2D3_D4D5_D6D7, 3'd0, 1'b1, 1'b1);
    drain();
    chk("post_rst_beats", vld_cycles, 4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/avalon_downsizer.md
AVALON_DOWNSIZER -- requirements
Module: avalon_downsizer

Interface
REQ-001 SHALL have parameter SYMBOL_WIDTH, default 8, giving bits per Avalon-ST symbol.
REQ-002 SHALL have parameter IN_SYMBOLS, default 8, giving symbols per input beat; power of 2, at least 2.
REQ-003 SHALL have parameter RATIO, default 4, giving output beats per full input beat; power of 2, at least 2, dividing IN_SYMBOLS; OUT_SYMBOLS = IN_SYMBOLS/RATIO.
REQ-004 SHALL have port clk, input, 1 bit: clock, all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port msg_in, avalon_st_if.slave, DATA_WIDTH = SYMBOL_WIDTH*IN_SYMBOLS: upstream stream (data, empty, sop, eop, vld, rdy), normally fed by avalon_sampler.
REQ-007 SHALL have port msg_out, avalon_st_if.master, DATA_WIDTH = SYMBOL_WIDTH*OUT_SYMBOLS: downstream narrow stream.
REQ-008 SHALL have port frame_err, output, 1 bit: one-cycle pulse on an input framing violation.
REQ-009 SHALL fatal at elaboration on a parameter rule violation or an interface DATA_WIDTH mismatch.

Function
REQ-010 SHALL hold exactly one accepted input beat in a holding register with states EMPTY and ACTIVE.
REQ-011 SHALL drive msg_in.rdy = (state==EMPTY) | (last sub-beat on msg_out & msg_out.rdy); combinational from registered state, no path from msg_in.vld.
REQ-012 SHALL go EMPTY->ACTIVE on input transfer (vld&rdy) and ACTIVE->EMPTY on last sub-beat transfer with no simultaneous input transfer; last sub-beat with input transfer stays ACTIVE and reloads.
REQ-013 SHALL present first sub-beat the cycle after input transfer (latency 1) and sustain one output beat per cycle while msg_out.rdy=1, including across input beat boundaries.
REQ-014 SHALL drive msg_out.vld = (state==ACTIVE).
REQ-015 SHALL emit sub-beat k (k=0..) as input symbols k*OUT_SYMBOLS .. k*OUT_SYMBOLS+OUT_SYMBOLS-1, symbol 0 at MSBs on both sides.
REQ-016 SHALL, for non-eop input beats, emit RATIO sub-beats and ignore input empty.
REQ-017 SHALL, for eop input beats with V = IN_SYMBOLS-empty, emit N = ceil(V/OUT_SYMBOLS) sub-beats, last with empty = N*OUT_SYMBOLS-V.
REQ-018 SHALL assert msg_out.sop only on sub-beat 0 of an input sop beat, msg_out.eop only on the last sub-beat of an input eop beat; msg_out.empty SHALL be 0 elsewhere.
REQ-019 SHALL hold msg_out data/empty/sop/eop stable while vld=1 and rdy=0.
REQ-020 SHALL keep sub-beat counter width log2(RATIO), reset to 0 on every load.
REQ-021 SHALL track in-packet state on input transfers and pulse frame_err the cycle after a transfer of sop while in-packet, or non-sop while not in-packet.
REQ-022 SHALL forward data unchanged on frame_err; in-packet state follows the received sop/eop.
REQ-023 SHALL treat a sop+eop beat as complete single-beat packet.

Reset
REQ-024 SHALL, during and after reset, hold state EMPTY, counter 0, in-packet 0, msg_out.vld 0, msg_out data/empty/sop/eop 0, frame_err 0, msg_in.rdy 1.
REQ-025 SHALL discard a held beat on reset mid-packet, with no partial sub-beats afterwards.

Structure
REQ-026 SHALL place state enum typedef, empty-width function (clog2) and default SYMBOL_WIDTH in shared package avalon_pkg.
REQ-027 SHALL implement the sub-beat counter with last-sub-beat detect (from eop/empty) as one sub-module _sub_beat_cnt.

Verification
REQ-028 SHALL check: 0x0011223344556677 sop eop empty 0, out rdy=1 -> 0x0011 sop, 0x2233, 0x4455, 0x6677 eop empty 0 on four consecutive cycles.
REQ-029 SHALL check: same data eop empty 3 -> three beats, last 0x44xx eop empty 1; empty 6 -> single 0x0011 sop eop empty 0.
REQ-030 SHALL check: two back-to-back 8-symbol beats, out rdy=1 -> eight output beats with no vld gap; in rdy high only on cycle of last sub-beat.
REQ-031 SHALL check: out rdy random 50% -> output sequence unchanged, outputs stable while stalled.
REQ-032 SHALL check: sop, sop (no eop), then beat without sop after eop -> frame_err pulses twice, data still forwarded.
REQ-033 SHALL check: rst_n low during sub-beat 2 -> vld 0 immediately, in rdy 1, next packet starts clean at sub-beat 0.
